// File: rtl/lvdc_phase_gen.sv
// Bit-time phase generator for the LVDC timing chain: divides the master clock into
// bit times, emits one-cycle phase strobes and tracks the bit time within a word.
module lvdc_phase_gen #(
  parameter int PHASES_PER_BIT = 8,
  parameter int BITS_PER_WORD  = 14,
  parameter int V1_PHASE       = 1,
  parameter int V4_PHASE       = 4,
  parameter int Y5_PHASE       = 5,
  parameter int W7_PHASE       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  output logic       v1,
  output logic       v4mod1,
  output logic       y5,
  output logic       w7,
  output logic [3:0] phase,
  output logic [3:0] bit_time,
  output logic       word_strobe,
  output logic       halted
);

  if (PHASES_PER_BIT < 8 || PHASES_PER_BIT > 16 ||
      BITS_PER_WORD < 2 || BITS_PER_WORD > 16 ||
      V1_PHASE < 0 || V1_PHASE >= PHASES_PER_BIT ||
      V4_PHASE < 0 || V4_PHASE >= PHASES_PER_BIT ||
      Y5_PHASE < 0 || Y5_PHASE >= PHASES_PER_BIT ||
      W7_PHASE < 0 || W7_PHASE >= PHASES_PER_BIT ||
      V1_PHASE == V4_PHASE || V1_PHASE == Y5_PHASE || V1_PHASE == W7_PHASE ||
      V4_PHASE == Y5_PHASE || V4_PHASE == W7_PHASE || Y5_PHASE == W7_PHASE) begin : g_param_check
    $error("lvdc_phase_gen: illegal phase/word parameters");
  end

  typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_e;

  localparam logic [3:0] LAST_PH  = 4'(PHASES_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_WORD - 1);
  localparam logic [3:0] V1_P     = 4'(V1_PHASE);
  localparam logic [3:0] V4_P     = 4'(V4_PHASE);
  localparam logic [3:0] Y5_P     = 4'(Y5_PHASE);
  localparam logic [3:0] W7_P     = 4'(W7_PHASE);

  state_e     state_q, state_d;
  logic       run_q, step_q;
  logic [3:0] phase_q, phase_d;
  logic [3:0] bit_q, bit_d;
  logic       v1_q, v1_d, v4_q, v4_d, y5_q, y5_d, w7_q, w7_d;
  logic       word_q, word_d, halted_q, halted_d;
  logic       active_d;

  // run/step are captured first; the sequencer acts on the captured copies so
  // no output ever depends combinationally on an input.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (state_q == ST_HALT) begin
      phase_d = 4'd0;
      if (run_q)       state_d = ST_RUN;
      else if (step_q) state_d = ST_STEP;
    end else if (phase_q == LAST_PH) begin
      phase_d = 4'd0;
      bit_d   = (bit_q == LAST_BIT) ? 4'd0 : bit_q + 4'd1;
      if (state_q == ST_STEP || !run_q) state_d = ST_HALT;
    end else begin
      phase_d = phase_q + 4'd1;
    end

    active_d = (state_d != ST_HALT);
    v1_d     = active_d && (phase_d == V1_P);
    v4_d     = active_d && (phase_d == V4_P);
    y5_d     = active_d && (phase_d == Y5_P);
    w7_d     = active_d && (phase_d == W7_P);
    word_d   = active_d && (phase_d == LAST_PH) && (bit_d == LAST_BIT);
    halted_d = !active_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HALT;
      run_q    <= 1'b0;
      step_q   <= 1'b0;
      phase_q  <= 4'd0;
      bit_q    <= 4'd0;
      v1_q     <= 1'b0;
      v4_q     <= 1'b0;
      y5_q     <= 1'b0;
      w7_q     <= 1'b0;
      word_q   <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      run_q    <= run;
      step_q   <= step;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      v1_q     <= v1_d;
      v4_q     <= v4_d;
      y5_q     <= y5_d;
      w7_q     <= w7_d;
      word_q   <= word_d;
      halted_q <= halted_d;
    end
  end

  assign v1          = v1_q;
  assign v4mod1      = v4_q;
  assign y5          = y5_q;
  assign w7          = w7_q;
  assign phase       = phase_q;
  assign bit_time    = bit_q;
  assign word_strobe = word_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_lvdc_phase_gen.sv
// Randomized and directed bench for lvdc_phase_gen against a behavioural model.
module tb_lvdc_phase_gen;

  localparam int P   = 8;
  localparam int B   = 14;
  localparam int PV1 = 1, PV4 = 4, PY5 = 5, PW7 = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1, run = 1'b0, step = 1'b0;
  logic       v1, v4mod1, y5, w7, word_strobe, halted;
  logic [3:0] phase, bit_time;

  lvdc_phase_gen #(
    .PHASES_PER_BIT(P), .BITS_PER_WORD(B),
    .V1_PHASE(PV1), .V4_PHASE(PV4), .Y5_PHASE(PY5), .W7_PHASE(PW7)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .v1(v1), .v4mod1(v4mod1), .y5(y5), .w7(w7),
    .phase(phase), .bit_time(bit_time),
    .word_strobe(word_strobe), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, last_ws = -1;
  bit ws_track = 1'b0;
  int n_v1, n_v4, n_y5, n_w7, n_ws, max_bt;

  // Behavioural model: mode 0 = halted, 1 = free-running, 2 = single bit time.
  // Requests take effect one edge after they are seen.
  int m_mode = 0, m_pos = 0, m_bt = 0;
  bit m_run_seen = 1'b0, m_step_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r_rst, input bit r_run, input bit r_step);
    if (r_rst) begin
      m_mode = 0; m_pos = 0; m_bt = 0; m_run_seen = 0; m_step_seen = 0;
      return;
    end
    if (m_mode == 0) begin
      m_pos  = 0;
      m_mode = m_run_seen ? 1 : (m_step_seen ? 2 : 0);
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == P) begin
        m_pos = 0;
        m_bt  = (m_bt + 1) % B;
        if (m_mode == 2 || !m_run_seen) m_mode = 0;
      end
    end
    m_run_seen  = r_run;
    m_step_seen = r_step;
  endtask

  function automatic logic [13:0] model_outs();
    bit act;
    act = (m_mode != 0);
    return {act && m_pos == PV1, act && m_pos == PV4, act && m_pos == PY5, act && m_pos == PW7,
            act && m_pos == P - 1 && m_bt == B - 1, !act, 4'(m_pos), 4'(m_bt)};
  endfunction

  task automatic clear_counts();
    n_v1 = 0; n_v4 = 0; n_y5 = 0; n_w7 = 0; n_ws = 0; max_bt = 0;
  endtask

  task automatic cycle();
    bit r_rst, r_run, r_step;
    r_rst = rst; r_run = run; r_step = step;
    @(posedge clk);
    cyc++;
    model_edge(r_rst, r_run, r_step);
    #1;
    chk("outs", {v1, v4mod1, y5, w7, word_strobe, halted, phase, bit_time}, model_outs());
    chk("one_strobe", 32'(int'(v1) + int'(v4mod1) + int'(y5) + int'(w7) <= 1), 32'd1);
    n_v1 += int'(v1); n_v4 += int'(v4mod1); n_y5 += int'(y5); n_w7 += int'(w7);
    n_ws += int'(word_strobe);
    if (int'(bit_time) > max_bt) max_bt = int'(bit_time);
    if (word_strobe) begin
      chk("ws_pos", {phase, bit_time}, {4'(P - 1), 4'(B - 1)});
      if (ws_track && last_ws >= 0) chk("ws_period", cyc - last_ws, P * B);
      last_ws = cyc;
    end
  endtask

  task automatic wait_pos(input int bt, input int ph, input int limit);
    int k;
    k = 0;
    while (!(int'(bit_time) == bt && int'(phase) == ph && !halted) && k < limit) begin
      cycle();
      k++;
    end
    chk("wait_pos_timeout", 32'(k < limit), 32'd1);
  endtask

  task automatic wait_halt(input int limit);
    int k;
    k = 0;
    while (!halted && k < limit) begin
      cycle();
      k++;
    end
    chk("wait_halt_timeout", 32'(k < limit), 32'd1);
  endtask

  initial begin
    // reset and idle
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_halted", halted, 1);
    chk("rst_phase", phase, 0);
    chk("rst_bit", bit_time, 0);
    chk("rst_strobes", {v1, v4mod1, y5, w7, word_strobe}, 0);
    rst = 1'b0;
    clear_counts();
    repeat (20) cycle();
    chk("idle_strobes", n_v1 + n_v4 + n_y5 + n_w7 + n_ws, 0);

    // free run
    run = 1'b1;
    cycle(); cycle();
    chk("start_phase", {halted, phase}, 5'd0);
    cycle();
    chk("start_v1", v1, 1);
    ws_track = 1'b1;
    clear_counts();
    repeat (2 * P * B) cycle();
    chk("run_v1_cnt", n_v1, 2 * B);
    chk("run_v4_cnt", n_v4, 2 * B);
    chk("run_y5_cnt", n_y5, 2 * B);
    chk("run_w7_cnt", n_w7, 2 * B);
    chk("run_ws_cnt", n_ws, 2);
    chk("run_max_bt", max_bt, B - 1);
    ws_track = 1'b0;

    // halt mid-bit
    wait_pos(5, 2, 300);
    run = 1'b0;
    clear_counts();
    wait_halt(20);
    chk("halt_y5", n_y5, 1);
    chk("halt_w7", n_w7, 1);
    chk("halt_bit", bit_time, 6);
    clear_counts();
    repeat (20) cycle();
    chk("halt_quiet", n_v1 + n_v4 + n_y5 + n_w7, 0);

    // single step from bit 3, with an ignored second pulse
    run = 1'b1;
    wait_pos(2, 2, 300);
    run = 1'b0;
    wait_halt(20);
    chk("pre_step_bit", bit_time, 3);
    clear_counts();
    step = 1'b1; cycle(); step = 1'b0;
    wait_pos(3, 3, 10);
    step = 1'b1; cycle(); step = 1'b0;
    repeat (20) cycle();
    chk("step_cnt", {8'(n_v1), 8'(n_v4), 8'(n_y5), 8'(n_w7)}, 32'h01010101);
    chk("step_end", {halted, bit_time}, {1'b1, 4'd4});

    // run and step together: run wins
    run = 1'b1; step = 1'b1; cycle(); step = 1'b0;
    cycle();
    clear_counts();
    repeat (3 * P) cycle();
    chk("rs_halted", halted, 0);
    chk("rs_v1_cnt", n_v1, 3);

    // reset mid-bit
    wait_pos(9, 4, 300);
    chk("rstmid_v4", v4mod1, 1);
    rst = 1'b1; run = 1'b0;
    cycle();
    rst = 1'b0;
    chk("rstmid_state", {halted, phase, bit_time}, {1'b1, 8'd0});
    clear_counts();
    repeat (10) cycle();
    chk("rstmid_quiet", n_v1 + n_v4 + n_y5 + n_w7, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) run = ~run;
      step = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; run = 1'b0; step = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
